// File: rtl/core_pkg.sv
// Shared core-wide widths and register-file types.
package core_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/decoder_5to32.sv
// One-hot write-enable decode for the register file; x0 never gets an enable.
module decoder_5to32
  import core_pkg::*;
(
  input  logic                wren,
  input  reg_addr_t           addr,
  output logic [NUM_REGS-1:0] we
);

  always_comb begin
    we       = '0;
    we[addr] = wren;
    we[0]    = 1'b0;
  end

endmodule

// File: rtl/regfile_32x32.sv
// 32x32 integer register file: two combinational read ports, one debug read port,
// one synchronous write port, optional same-cycle write forwarding on rs1/rs2.
module regfile_32x32
  import core_pkg::*;
#(
  parameter int BYPASS = 0
) (
  input  logic  i_clk,
  input  logic  i_reset,
  input  logic  [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic  [REG_ADDR_W-1:0] i_rs2_addr,
  output logic  [XLEN-1:0]       o_rs1_data,
  output logic  [XLEN-1:0]       o_rs2_data,
  input  logic  i_rd_wren,
  input  logic  [REG_ADDR_W-1:0] i_rd_addr,
  input  logic  [XLEN-1:0]       i_rd_data,
  input  logic  [REG_ADDR_W-1:0] i_dbg_addr,
  output logic  [XLEN-1:0]       o_dbg_data
);

  xlen_t               regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] we;
  xlen_t               rs1_stored;
  xlen_t               rs2_stored;

  decoder_5to32 u_dec (
    .wren (i_rd_wren),
    .addr (i_rd_addr),
    .we   (we)
  );

  // Reset wins over a coincident write; x0 has no storage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (we[i]) regs[i] <= i_rd_data;
    end
  end

  function automatic xlen_t read_sel(input reg_addr_t addr);
    if (addr == '0) return '0;
    return regs[addr];
  endfunction

  assign rs1_stored = read_sel(i_rs1_addr);
  assign rs2_stored = read_sel(i_rs2_addr);
  assign o_dbg_data = read_sel(i_dbg_addr);

  // Forwarding is purely combinational, so it also applies while reset is held.
  generate
    if (BYPASS != 0) begin : g_bypass
      logic hit1;
      logic hit2;
      assign hit1 = i_rd_wren && (i_rd_addr == i_rs1_addr) && (i_rd_addr != '0);
      assign hit2 = i_rd_wren && (i_rd_addr == i_rs2_addr) && (i_rd_addr != '0);
      assign o_rs1_data = hit1 ? i_rd_data : rs1_stored;
      assign o_rs2_data = hit2 ? i_rd_data : rs2_stored;
    end else begin : g_no_bypass
      assign o_rs1_data = rs1_stored;
      assign o_rs2_data = rs2_stored;
    end
  endgenerate

endmodule
